// File: rtl/heartrate_pkg.sv
// Shared types, widths and the BPM-to-level quantiser for the heart-rate display front end.
package heartrate_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DIV   = 2'd2
    } hr_state_t;

    localparam logic [15:0] MS_PER_MIN = 16'd60000;
    localparam int INTERVAL_W = 12;
    localparam int BPM_W      = 8;
    localparam int LEVEL_W    = 4;

    // Below bpm_min maps to 0; above, one level per 2**shift BPM, clamped to 15.
    function automatic logic [LEVEL_W-1:0] quantise(
        input logic [BPM_W-1:0] bpm,
        input logic [BPM_W-1:0] bpm_min,
        input int               shift
    );
        logic [BPM_W-1:0] step;
        if (bpm < bpm_min) begin
            step     = 8'd0;
            quantise = 4'd0;
        end else begin
            step = (bpm - bpm_min) >> shift;
            if (step > 8'd15) begin
                quantise = 4'd15;
            end else begin
                quantise = step[LEVEL_W-1:0];
            end
        end
    endfunction

endpackage

// File: rtl/heartrate_level_if.sv
// Sensor beat input and display-side outputs of heartrate_level; master is the design side.
interface heartrate_level_if;
    import heartrate_pkg::*;

    logic               beat_in;
    logic [LEVEL_W-1:0] level;
    logic               level_valid;
    logic [BPM_W-1:0]   bpm;
    logic               no_pulse;

    modport master (input beat_in, output level, output level_valid, output bpm, output no_pulse);
    modport slave  (output beat_in, input level, input level_valid, input bpm, input no_pulse);

endinterface

// File: rtl/heartrate_level_bpm_divider.sv
// Restoring divider, one quotient bit per cycle over 16 cycles; quotient saturates at 255.
module bpm_divider
    import heartrate_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [15:0]           dividend,
    input  logic [INTERVAL_W-1:0] divisor,
    output logic                  busy,
    output logic                  done,
    output logic [BPM_W-1:0]      quotient
);

    logic [INTERVAL_W-1:0] rem_r;
    logic [INTERVAL_W-1:0] dsr_r;
    logic [15:0]           quo_r;
    logic [3:0]            cnt_r;
    logic                  busy_r;
    logic                  done_r;
    logic [BPM_W-1:0]      quotient_r;

    logic [INTERVAL_W:0]   shifted_s;
    logic [INTERVAL_W:0]   diff_s;
    logic                  fits_s;
    logic [INTERVAL_W-1:0] rem_next_s;
    logic [15:0]           quo_next_s;
    logic [BPM_W-1:0]      sat_s;

    // One restoring step; the remainder stays below the divisor so it fits INTERVAL_W bits.
    always_comb begin
        shifted_s = {rem_r, quo_r[15]};
        diff_s    = shifted_s - {1'b0, dsr_r};
        fits_s    = (shifted_s >= {1'b0, dsr_r});
        if (fits_s) begin
            rem_next_s = diff_s[INTERVAL_W-1:0];
        end else begin
            rem_next_s = shifted_s[INTERVAL_W-1:0];
        end
        quo_next_s = {quo_r[14:0], fits_s};
        if (quo_next_s[15:8] != 8'd0) begin
            sat_s = 8'd255;
        end else begin
            sat_s = quo_next_s[7:0];
        end
    end

    // Load on start, iterate while busy, pulse done with the saturated result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r      <= {INTERVAL_W{1'b0}};
            dsr_r      <= {INTERVAL_W{1'b0}};
            quo_r      <= 16'd0;
            cnt_r      <= 4'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            quotient_r <= 8'd0;
        end else begin
            done_r <= 1'b0;
            if (busy_r) begin
                rem_r <= rem_next_s;
                quo_r <= quo_next_s;
                cnt_r <= cnt_r + 4'd1;
                if (cnt_r == 4'd15) begin
                    busy_r     <= 1'b0;
                    done_r     <= 1'b1;
                    quotient_r <= sat_s;
                end
            end else if (start) begin
                rem_r  <= {INTERVAL_W{1'b0}};
                dsr_r  <= divisor;
                quo_r  <= dividend;
                cnt_r  <= 4'd0;
                busy_r <= 1'b1;
            end
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign quotient = quotient_r;

endmodule

// File: rtl/heartrate_level.sv
// Beat interval -> BPM -> 4-bit level for the bar-graph display.
// Optional HR_AVERAGE_EN: divide by the mean of the last 4 accepted intervals.
module heartrate_level
    import heartrate_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRACT_MS = 250,
    parameter int TIMEOUT_MS = 3000,
    parameter int BPM_MIN    = 40,
    parameter int BPM_SHIFT  = 3
)
(
    input logic               clk,
    input logic               rst_n,
    heartrate_level_if.master hr
);

    localparam int TICK_CYC = CLK_HZ / 1000;
    localparam int PRE_W    = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam logic [PRE_W-1:0]      PRE_MAX   = PRE_W'(TICK_CYC - 1);
    localparam logic [INTERVAL_W-1:0] REFRACT_V = INTERVAL_W'(REFRACT_MS);
    localparam logic [INTERVAL_W-1:0] TIMEOUT_V = INTERVAL_W'(TIMEOUT_MS);
    localparam logic [BPM_W-1:0]      BPM_MIN_V = BPM_W'(BPM_MIN);

    logic [1:0]            sync_r;
    logic                  prev_r;
    logic                  strobe_r;
    logic [PRE_W-1:0]      pre_r;
    logic [INTERVAL_W-1:0] cnt_r;
    hr_state_t             state_r;
    logic [LEVEL_W-1:0]    level_r;
    logic                  level_valid_r;
    logic [BPM_W-1:0]      bpm_r;
    logic                  no_pulse_r;

    logic                  tick_s;
    logic [INTERVAL_W-1:0] cnt_inc_s;
    logic                  accept_s;
    logic                  start_s;
    logic                  timeout_s;
    logic [INTERVAL_W-1:0] divisor_s;
    logic                  div_busy_s;
    logic                  div_done_s;
    logic [BPM_W-1:0]      div_quotient_s;

    // Synchronise the sensor comparator and turn its rising edge into a one-cycle strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r   <= 2'b00;
            prev_r   <= 1'b0;
            strobe_r <= 1'b0;
        end else begin
            sync_r   <= {sync_r[0], hr.beat_in};
            prev_r   <= sync_r[1];
            strobe_r <= sync_r[1] & ~prev_r;
        end
    end

    // cnt_inc_s includes this cycle's tick so a beat exactly N ms after the last one reads N.
    always_comb begin
        tick_s = (pre_r == PRE_MAX);
        if (tick_s && (cnt_r < TIMEOUT_V)) begin
            cnt_inc_s = cnt_r + INTERVAL_W'(1);
        end else begin
            cnt_inc_s = cnt_r;
        end
        accept_s  = strobe_r && ((state_r == IDLE) || (cnt_inc_s >= REFRACT_V));
        start_s   = accept_s && (state_r == ARMED) && !div_busy_s;
        timeout_s = !accept_s && (state_r == ARMED) && (cnt_inc_s >= TIMEOUT_V);
    end

    // Millisecond prescaler and saturating interval counter, restarted by any accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_r <= {PRE_W{1'b0}};
            cnt_r <= {INTERVAL_W{1'b0}};
        end else begin
            if (tick_s) begin
                pre_r <= {PRE_W{1'b0}};
            end else begin
                pre_r <= pre_r + PRE_W'(1);
            end
            if (accept_s) begin
                cnt_r <= {INTERVAL_W{1'b0}};
            end else begin
                cnt_r <= cnt_inc_s;
            end
        end
    end

`ifdef HR_AVERAGE_EN
    logic [INTERVAL_W-1:0] hist_r [3];
    logic                  fresh_r;
    logic [INTERVAL_W+1:0] sum_s;

    // Mean of the three stored intervals plus the one just measured.
    always_comb begin
        sum_s = {2'b00, hist_r[0]} + {2'b00, hist_r[1]} + {2'b00, hist_r[2]} + {2'b00, cnt_inc_s};
        if (fresh_r) begin
            divisor_s = cnt_inc_s;
        end else begin
            divisor_s = sum_s[INTERVAL_W+1:2];
        end
    end

    // History is emptied while idle; the first interval afterwards fills every slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_r[0] <= {INTERVAL_W{1'b0}};
            hist_r[1] <= {INTERVAL_W{1'b0}};
            hist_r[2] <= {INTERVAL_W{1'b0}};
            fresh_r   <= 1'b1;
        end else if (state_r == IDLE) begin
            hist_r[0] <= {INTERVAL_W{1'b0}};
            hist_r[1] <= {INTERVAL_W{1'b0}};
            hist_r[2] <= {INTERVAL_W{1'b0}};
            fresh_r   <= 1'b1;
        end else if (start_s) begin
            fresh_r <= 1'b0;
            if (fresh_r) begin
                hist_r[0] <= cnt_inc_s;
                hist_r[1] <= cnt_inc_s;
                hist_r[2] <= cnt_inc_s;
            end else begin
                hist_r[0] <= cnt_inc_s;
                hist_r[1] <= hist_r[0];
                hist_r[2] <= hist_r[1];
            end
        end
    end
`else
    assign divisor_s = cnt_inc_s;
`endif

    bpm_divider u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_s),
        .dividend (MS_PER_MIN),
        .divisor  (divisor_s),
        .busy     (div_busy_s),
        .done     (div_done_s),
        .quotient (div_quotient_s)
    );

    // Control FSM with registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            level_r       <= 4'd0;
            level_valid_r <= 1'b0;
            bpm_r         <= 8'd0;
            no_pulse_r    <= 1'b1;
        end else begin
            level_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    no_pulse_r <= 1'b1;
                    if (accept_s) begin
                        state_r <= ARMED;
                    end
                end
                ARMED: begin
                    if (start_s) begin
                        state_r <= DIV;
                    end else if (timeout_s) begin
                        level_r       <= 4'd0;
                        bpm_r         <= 8'd0;
                        no_pulse_r    <= 1'b1;
                        level_valid_r <= 1'b1;
                        state_r       <= IDLE;
                    end
                end
                DIV: begin
                    if (div_done_s) begin
                        bpm_r         <= div_quotient_s;
                        level_r       <= quantise(div_quotient_s, BPM_MIN_V, BPM_SHIFT);
                        no_pulse_r    <= 1'b0;
                        level_valid_r <= 1'b1;
                        state_r       <= ARMED;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign hr.level       = level_r;
    assign hr.level_valid = level_valid_r;
    assign hr.bpm         = bpm_r;
    assign hr.no_pulse    = no_pulse_r;

endmodule
